// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus multi-cycle shift-add multiply.
// Define SEQ_ALU_DIV_EN to build the restoring divider for ops 9 (DIVU) and 10 (REMU).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             zero,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;
  // acc: product accumulator / partial remainder; x: multiplicand / dividend-quotient; y: multiplier / divisor
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] alu_res, mul_next;
  logic             alu_err, multi, accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == SHW'(WIDTH - 1));
  assign sign      = result[WIDTH-1];
  assign zero      = (result == '0);
  assign mul_next  = acc + (y[0] ? x : '0);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (ALUOp)
      4'd0: alu_res = A + B;
      4'd1: alu_res = A - B;
      4'd2: alu_res = B << A[SHW-1:0];
      4'd3: alu_res = A | B;
      4'd4: alu_res = A & B;
      4'd5: alu_res[0] = (A < B);
      4'd6: alu_res[0] = ($signed(A) < $signed(B));
      4'd7: alu_res = A ^ B;
      default: alu_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   trial;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next, quo_next;

  // One restoring step: shift the next dividend bit into the remainder, keep the subtract if it fits
  always_comb begin
    trial    = {acc, x[WIDTH-1]} - {1'b0, y};
    div_ok   = !trial[WIDTH];
    rem_next = div_ok ? trial[WIDTH-1:0] : {acc[WIDTH-2:0], x[WIDTH-1]};
    quo_next = {x[WIDTH-2:0], div_ok};
  end

  assign multi = (ALUOp == 4'd8) || (ALUOp == 4'd9) || (ALUOp == 4'd10);
`else
  assign multi = (ALUOp == 4'd8);
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= ALUOp;
          cnt  <= '0;
          acc  <= '0;
          x    <= A;
          y    <= B;
          if (multi) begin
            state <= CALC;
          end else begin
            result <= alu_res;
            err    <= alu_err;
            state  <= DONE;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
`ifdef SEQ_ALU_DIV_EN
          if (op_q != 4'd8) begin
            acc <= rem_next;
            x   <= quo_next;
            if (last) result <= (op_q == 4'd9) ? quo_next : rem_next;
          end else
`endif
          begin
            acc <= mul_next;
            x   <= x << 1;
            y   <= y >> 1;
            if (last) result <= mul_next;
          end
          if (last) begin
            err   <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
